// File: rtl/ysyx_23060203_raw_scb.sv
// Read-after-write scoreboard: per-register pending-write counters that stall
// issue while a source or a saturated destination still has writes in flight.
module ysyx_23060203_raw_scb #(
   parameter int unsigned AW        = 5,
   parameter int unsigned CNT_W     = 2,
   parameter int unsigned NWB       = 2,
   parameter int unsigned WB_BYPASS = 1
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  flush,
   input  logic                  iss_valid,
   output logic                  iss_ready,
   input  logic [AW-1:0]         iss_rd,
   input  logic [AW-1:0]         iss_rs1,
   input  logic [AW-1:0]         iss_rs2,
   input  logic                  iss_rs1_en,
   input  logic                  iss_rs2_en,
   input  logic [NWB-1:0]        wb_valid,
   input  logic [NWB*AW-1:0]     wb_rd,
   output logic                  busy_rs1,
   output logic                  busy_rs2,
   output logic                  idle,
   output logic [AW+CNT_W-1:0]   inflight,
   output logic                  err
);

   localparam int unsigned NREG = 1 << AW;
   localparam int unsigned HW   = $clog2(NWB + 1);
   localparam int unsigned SW   = CNT_W + HW + 1;
   localparam int unsigned IW   = AW + CNT_W;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [CNT_W-1:0] cnt_q [NREG];
   logic [CNT_W-1:0] cnt_d [NREG];
   logic [HW-1:0]    hits  [NREG];
   logic [SW-1:0]    sum;
   logic [IW-1:0]    inflight_q;
   logic [IW-1:0]    inflight_d;
   logic             err_q;
   logic             err_d;
   logic             rd_full;
   logic             accept;

   // Number of valid writeback ports targeting each register this cycle
   always_comb begin
      for (int r = 0; r < NREG; r++) hits[r] = '0;
      for (int k = 0; k < NWB; k++) begin
         if (wb_valid[k] && (wb_rd[k*AW +: AW] != '0)) begin
            hits[wb_rd[k*AW +: AW]] = hits[wb_rd[k*AW +: AW]] + HW'(1);
         end
      end
   end

   // Source hazards; with bypass a same-cycle writeback retires the pending write early
   always_comb begin
      busy_rs1 = 1'b0;
      busy_rs2 = 1'b0;
      if (iss_rs1 != '0) begin
         busy_rs1 = (WB_BYPASS != 0) ? (SW'(cnt_q[iss_rs1]) > SW'(hits[iss_rs1]))
                                     : (cnt_q[iss_rs1] != '0);
      end
      if (iss_rs2 != '0) begin
         busy_rs2 = (WB_BYPASS != 0) ? (SW'(cnt_q[iss_rs2]) > SW'(hits[iss_rs2]))
                                     : (cnt_q[iss_rs2] != '0);
      end
   end

   assign rd_full   = (iss_rd != '0) && (cnt_q[iss_rd] == CNT_MAX);
   assign iss_ready = ~(iss_rs1_en & busy_rs1) & ~(iss_rs2_en & busy_rs2) & ~rd_full & ~flush;
   assign accept    = iss_valid & iss_ready;

   // Net per-register update: +1 for an accepted issue, -hits for writebacks, floored at 0
   always_comb begin
      err_d      = err_q;
      inflight_d = '0;
      sum        = '0;
      for (int r = 0; r < NREG; r++) cnt_d[r] = '0;
      if (!flush) begin
         for (int r = 1; r < NREG; r++) begin
            sum = SW'(cnt_q[r]) + SW'(accept && (iss_rd == AW'(r)));
            if (sum < SW'(hits[r])) begin
               cnt_d[r] = '0;
               err_d    = 1'b1;
            end else begin
               cnt_d[r] = CNT_W'(sum - SW'(hits[r]));
            end
         end
      end
      for (int r = 0; r < NREG; r++) inflight_d = inflight_d + IW'(cnt_d[r]);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int r = 0; r < NREG; r++) cnt_q[r] <= '0;
         inflight_q <= '0;
         err_q      <= 1'b0;
      end else begin
         for (int r = 0; r < NREG; r++) cnt_q[r] <= cnt_d[r];
         inflight_q <= inflight_d;
         err_q      <= err_d;
      end
   end

   assign inflight = inflight_q;
   assign idle     = (inflight_q == '0);
   assign err      = err_q;

endmodule
